// File: rtl/alu_issue_buffer_pkg.sv
// Shared ALU op encodings and default widths for the ALU and its issue buffer.
// Combinational constants only; no latency, no flow control.
package alu_issue_buffer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int RD_W_DEF   = 3;
  localparam int OP_W       = 2;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_OR  = 2'b11;

  // Width of one buffered op: {op, a, b, rd}.
  function automatic int entry_width(input int data_w, input int rd_w);
    return OP_W + 2 * data_w + rd_w;
  endfunction

endpackage

// File: rtl/alu_issue_buffer_sync_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; head visible the cycle after write.
// Caller must not push when full or pop when empty; clear discards same-cycle push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clear && !rst;
  assign do_pop  = pop  && !clear && !rst;

  // Storage has no reset; stale contents are harmless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_buffer.sv
// ALU issue buffer: FIFO of decoded ops feeding the ALU, result captured into a writeback reg.
// Accept-to-wb_valid is 2 edges when idle; in_ready ignores same-cycle pops (full means stall).
module alu_issue_buffer
  import alu_issue_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_op,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [RD_W-1:0]        in_rd,
  output logic [DATA_W-1:0]      alu_in1,
  output logic [DATA_W-1:0]      alu_in2,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_zero,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DATA_W-1:0]      wb_result,
  output logic                   wb_zero,
  output logic [RD_W-1:0]        wb_rd,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ENT_W = entry_width(DATA_W, RD_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] head_ent;
  logic [RD_W-1:0]  head_rd;
  logic             push;
  logic             pop;

  assign in_ent = {in_op, in_a, in_b, in_rd};
  assign {alu_op, alu_in1, alu_in2, head_rd} = head_ent;

  // Full is judged on registered occupancy only, keeping wb_ready off the in_ready path.
  assign in_ready = !rst && (count != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!wb_valid || wb_ready);

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_ent),
    .head  (head_ent),
    .count (count)
  );

  // A squash only invalidates the writeback slot; its payload is left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_result <= '0;
      wb_zero   <= 1'b0;
      wb_rd     <= '0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
    end else if (pop) begin
      wb_valid  <= 1'b1;
      wb_result <= alu_result;
      wb_zero   <= alu_zero;
      wb_rd     <= head_rd;
    end else if (wb_ready) begin
      wb_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Bench for alu_issue_buffer with an in-bench ALU and a queue-based reference model.
module tb_alu_issue_buffer;
  import alu_issue_buffer_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int RW    = 3;

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
  } op_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_a, in_b;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] alu_in1, alu_in2, alu_result;
  logic [1:0]    alu_op;
  logic          alu_zero;
  logic          wb_valid, wb_ready, wb_zero;
  logic [DW-1:0] wb_result;
  logic [RW-1:0] wb_rd;
  logic [2:0]    count;

  int errors = 0;
  int checks = 0;

  // Reference model state: ops held in the FIFO, and the writeback slot.
  op_t fq[$];
  bit  wb_has;
  op_t wb_ent;

  always #5 clk = ~clk;

  alu_issue_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .RD_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_zero(wb_zero), .wb_rd(wb_rd),
    .count(count)
  );

  // The 16-bit ALU sitting downstream of the buffer.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = alu_in1 + alu_in2;
      ALU_SUB: alu_result = alu_in1 - alu_in2;
      ALU_AND: alu_result = alu_in1 & alu_in2;
      default: alu_result = alu_in1 | alu_in2;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  function automatic logic [DW-1:0] ref_res(input op_t e);
    int unsigned r;
    case (e.op)
      ALU_ADD: r = (int'(e.a) + int'(e.b)) % 65536;
      ALU_SUB: r = (int'(e.a) - int'(e.b) + 65536) % 65536;
      ALU_AND: r = int'(e.a & e.b);
      default: r = int'(e.a | e.b);
    endcase
    return DW'(r);
  endfunction

  function automatic op_t mk(input logic [1:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [RW-1:0] rd);
    op_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd;
    return e;
  endfunction

  task automatic drive(input bit v, input op_t e);
    in_valid = v;
    in_op    = e.op;
    in_a     = e.a;
    in_b     = e.b;
    in_rd    = e.rd;
  endtask

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic tick();
    bit push_m, pop_m, rel_m;
    if (rst || flush) begin
      fq.delete();
      wb_has = 1'b0;
    end else begin
      push_m = in_valid && (fq.size() != DEPTH);
      pop_m  = (fq.size() != 0) && (!wb_has || wb_ready);
      rel_m  = wb_has && wb_ready;
      if (pop_m) begin
        wb_ent = fq.pop_front();
        wb_has = 1'b1;
      end else if (rel_m) begin
        wb_has = 1'b0;
      end
      if (push_m) fq.push_back(mk(in_op, in_a, in_b, in_rd));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    tick(); tick();
    checks++; if (count !== 3'd0)      begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (wb_valid !== 1'b0)   begin errors++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_result !== 16'h0) begin errors++; $display("FAIL rst_wb_result: got %h want 0000", wb_result); end
    checks++; if (wb_zero !== 1'b0)    begin errors++; $display("FAIL rst_wb_zero: got %b want 0", wb_zero); end
    checks++; if (wb_rd !== 3'd0)      begin errors++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready_hi: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready_lo: got %b want 1", in_ready); end
  endtask

  task automatic test_single_add();
    wb_ready = 1'b1;
    drive(1'b1, mk(ALU_ADD, 16'h0003, 16'h0004, 3'd2));
    tick();
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    checks++; if (count !== 3'd1)        begin errors++; $display("FAIL add_count1: got %0d want 1", count); end
    checks++; if (wb_valid !== 1'b0)     begin errors++; $display("FAIL add_early_valid: got %b want 0", wb_valid); end
    tick();
    checks++; if (wb_valid !== 1'b1)     begin errors++; $display("FAIL add_valid: got %b want 1", wb_valid); end
    checks++; if (wb_result !== 16'h0007) begin errors++; $display("FAIL add_result: got %h want 0007", wb_result); end
    checks++; if (wb_zero !== 1'b0)      begin errors++; $display("FAIL add_zero: got %b want 0", wb_zero); end
    checks++; if (wb_rd !== 3'd2)        begin errors++; $display("FAIL add_rd: got %0d want 2", wb_rd); end
    checks++; if (count !== 3'd0)        begin errors++; $display("FAIL add_count0: got %0d want 0", count); end
    tick();
    checks++; if (wb_valid !== 1'b0)     begin errors++; $display("FAIL add_release: got %b want 0", wb_valid); end
  endtask

  task automatic test_zero_wrap();
    wb_ready = 1'b1;
    drive(1'b1, mk(ALU_SUB, 16'h1234, 16'h1234, 3'd5));
    tick();
    drive(1'b1, mk(ALU_ADD, 16'hFFFF, 16'h0001, 3'd6));
    tick();
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    checks++; if (wb_valid !== 1'b1 || wb_result !== 16'h0000 || wb_zero !== 1'b1 || wb_rd !== 3'd5) begin
      errors++; $display("FAIL sub_zero: got v=%b r=%h z=%b rd=%0d want v=1 r=0000 z=1 rd=5", wb_valid, wb_result, wb_zero, wb_rd);
    end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_result !== 16'h0000 || wb_zero !== 1'b1 || wb_rd !== 3'd6) begin
      errors++; $display("FAIL add_wrap: got v=%b r=%h z=%b rd=%0d want v=1 r=0000 z=1 rd=6", wb_valid, wb_result, wb_zero, wb_rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, mk(ALU_ADD, 16'(k * 256), 16'(k), 3'(k)));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: in_ready got %b want 1", k, in_ready); end
      tick();
    end
    drive(1'b1, mk(ALU_ADD, 16'h0600, 16'h0006, 3'd6));
    checks++; if (count !== 3'd4)    begin errors++; $display("FAIL bp_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_result !== 16'h0101) begin
      errors++; $display("FAIL bp_head: got v=%b rd=%0d r=%h want v=1 rd=1 r=0101", wb_valid, wb_rd, wb_result);
    end
    tick();
    checks++; if (count !== 3'd4 || wb_rd !== 3'd1 || wb_result !== 16'h0101) begin
      errors++; $display("FAIL bp_hold: got cnt=%0d rd=%0d r=%h want cnt=4 rd=1 r=0101", count, wb_rd, wb_result);
    end
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    wb_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (wb_valid !== 1'b1 || wb_result !== 16'(k * 257)) begin
        errors++; $display("FAIL bp_order%0d: got v=%b r=%h want v=1 r=%h", k, wb_valid, wb_result, 16'(k * 257));
      end
      tick();
    end
    checks++; if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL bp_drained: got v=%b cnt=%0d want v=0 cnt=0", wb_valid, count);
    end
  endtask

  task automatic test_full_push_pop();
    int guard;
    wb_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, mk(ALU_OR, 16'(k), 16'h0000, 3'(k)));
      tick();
    end
    drive(1'b1, mk(ALU_OR, 16'h0077, 16'h0000, 3'd7));
    wb_ready = 1'b1;
    checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL full_refuse: got rdy=%b cnt=%0d want rdy=0 cnt=4", in_ready, count);
    end
    tick();
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    checks++; if (count !== 3'd3 || wb_valid !== 1'b1 || wb_rd !== 3'd2) begin
      errors++; $display("FAIL full_pop: got cnt=%0d v=%b rd=%0d want cnt=3 v=1 rd=2", count, wb_valid, wb_rd);
    end
    guard = 0;
    while ((count != 3'd0 || wb_valid) && guard < 20) begin
      tick();
      guard++;
    end
    checks++; if (guard >= 20) begin errors++; $display("FAIL full_drain: timeout cnt=%0d v=%b want drained", count, wb_valid); end
  endtask

  task automatic test_back_to_back();
    op_t t[8];
    t[0] = mk(ALU_OR,  16'h00F0, 16'h0F00, 3'd0);
    t[1] = mk(ALU_AND, 16'hFF00, 16'h0FF0, 3'd1);
    t[2] = mk(ALU_AND, 16'hFFFF, 16'h1234, 3'd2);
    t[3] = mk(ALU_OR,  16'h0000, 16'h0000, 3'd3);
    t[4] = mk(ALU_AND, 16'hAAAA, 16'h5555, 3'd4);
    t[5] = mk(ALU_OR,  16'h8000, 16'h0001, 3'd5);
    t[6] = mk(ALU_AND, 16'($urandom), 16'($urandom), 3'd6);
    t[7] = mk(ALU_OR,  16'($urandom), 16'($urandom), 3'd7);
    wb_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) drive(1'b1, t[c]);
      else       drive(1'b0, mk(ALU_ADD, 0, 0, 0));
      tick();
      if (c >= 1) begin
        checks++; if (wb_valid !== 1'b1 || wb_result !== ref_res(t[c-1]) ||
                      wb_zero !== (ref_res(t[c-1]) == '0) || wb_rd !== t[c-1].rd) begin
          errors++; $display("FAIL b2b_%0d: got v=%b r=%h z=%b rd=%0d want v=1 r=%h rd=%0d",
                             c - 1, wb_valid, wb_result, wb_zero, wb_rd, ref_res(t[c-1]), t[c-1].rd);
        end
      end
    end
    checks++; if (ref_res(t[0]) !== wb_result && 1'b0) begin errors++; end
    tick();
    checks++; if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL b2b_end: got v=%b cnt=%0d want v=0 cnt=0", wb_valid, count);
    end
  endtask

  task automatic fill_three_plus_wb();
    wb_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, mk(ALU_ADD, 16'(k), 16'(k), 3'(k)));
      tick();
    end
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
  endtask

  task automatic test_flush();
    fill_three_plus_wb();
    checks++; if (count !== 3'd3 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL flush_pre: got cnt=%0d v=%b want cnt=3 v=1", count, wb_valid);
    end
    flush = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, mk(ALU_ADD, 16'h0055, 16'h0000, 3'd7));
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    checks++; if (count !== 3'd0 || wb_valid !== 1'b0 || wb_rd !== 3'd1) begin
      errors++; $display("FAIL flush_post: got cnt=%0d v=%b rd=%0d want cnt=0 v=0 rd=1", count, wb_valid, wb_rd);
    end
    tick();
    checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_nostore: got cnt=%0d v=%b want cnt=0 v=0", count, wb_valid);
    end
  endtask

  task automatic test_reset_mid();
    fill_three_plus_wb();
    rst = 1'b1;
    flush = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, mk(ALU_ADD, 16'h0055, 16'h0000, 3'd7));
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    checks++; if (count !== 3'd0 || wb_valid !== 1'b0 || wb_result !== 16'h0 || wb_rd !== 3'd0) begin
      errors++; $display("FAIL rmid_post: got cnt=%0d v=%b r=%h rd=%0d want all 0", count, wb_valid, wb_result, wb_rd);
    end
    tick();
    checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_nostore: got cnt=%0d v=%b want cnt=0 v=0", count, wb_valid);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, mk(ALU_ADD, 0, 0, 0));
    tick();
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      flush    = ($urandom_range(0, 49) == 0);
      wb_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7,
            mk(2'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 3'($urandom)));
      tick();
      checks++; if (count !== 3'(fq.size())) begin
        errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, fq.size());
      end
      checks++; if (wb_valid !== wb_has) begin
        errors++; $display("FAIL rnd_wb_valid@%0d: got %b want %b", n, wb_valid, wb_has);
      end
      checks++; if (in_ready !== (fq.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, fq.size() != DEPTH);
      end
      if (wb_has) begin
        checks++; if (wb_result !== ref_res(wb_ent) || wb_zero !== (ref_res(wb_ent) == '0) || wb_rd !== wb_ent.rd) begin
          errors++; $display("FAIL rnd_wb@%0d: got r=%h z=%b rd=%0d want r=%h rd=%0d",
                             n, wb_result, wb_zero, wb_rd, ref_res(wb_ent), wb_ent.rd);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_zero_wrap();
    test_backpressure();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
